// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the memory-fetch and execute-side signals of the instruction
//   fetch queue.
//
//   Signals:
//     mem_addr      fetch address (registered in the queue)
//     mem_strobe    read request; mem_data returns one edge later
//     mem_data      byte from the synchronous memory
//     redirect      jump request, sampled on the clock edge
//     redirect_addr jump target
//     instr_valid   whole instruction available at the queue head
//     instr_ready   execute stage accepts the presented instruction
//     instr_byte0-2 opcode and operand bytes (unused bytes read 0)
//     instr_len     instruction length 1..3
//     instr_pc      address of instr_byte0
//
//   Handshake: an instruction transfers on a rising edge where instr_valid
//   and instr_ready are both 1. While instr_valid=1 and instr_ready=0 all
//   instr_* outputs are held stable. instr_ready while instr_valid=0 has
//   no effect.
//
//   Modports: master = fetch queue side, slave = memory / execute side.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_strobe;
   logic [7:0]            mem_data;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_addr;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [7:0]            instr_byte0;
   logic [7:0]            instr_byte1;
   logic [7:0]            instr_byte2;
   logic [1:0]            instr_len;
   logic [ADDR_WIDTH-1:0] instr_pc;

   modport master (
      output mem_addr, mem_strobe,
      input  mem_data,
      input  redirect, redirect_addr,
      output instr_valid,
      input  instr_ready,
      output instr_byte0, instr_byte1, instr_byte2, instr_len, instr_pc
   );

   modport slave (
      input  mem_addr, mem_strobe,
      output mem_data,
      output redirect, redirect_addr,
      input  instr_valid,
      output instr_ready,
      input  instr_byte0, instr_byte1, instr_byte2, instr_len, instr_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Prefetches instruction bytes from a synchronous byte memory into a
//   DEPTH-byte circular queue, decodes the instruction length from the head
//   opcode and presents whole 1/2/3-byte instructions to execute.
//   A redirect flushes the queue and restarts fetch at the jump target.
//
//   Ports:
//     clk               rising-edge clock
//     rst_n             asynchronous active-low reset
//     bus (master)      memory fetch + instruction handshake, see fetch_queue_if
//     perf_flush_count  (FETCH_PERF_EN only) saturating count of redirects
//                       that discarded queued or in-flight bytes
//
//   Optional feature macro: FETCH_PERF_EN
//
//   Parameters:
//     ADDR_WIDTH  address width, addresses wrap modulo 2^ADDR_WIDTH
//     DEPTH       queue capacity in bytes, power of two, >= 4
//     RESET_PC    fetch and instruction PC after reset
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic           clk,
   input logic           rst_n,
   fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]   perf_flush_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Queue storage and bookkeeping
   logic [7:0]            fifo_q [DEPTH];
   logic [7:0]            fifo_d [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  rd_pending_q, rd_pending_d;
   logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
   logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;

   // Head window and handshake terms
   logic [PTR_W-1:0]      ptr1, ptr2;
   logic [7:0]            hb0, hb1, hb2;
   logic [1:0]            head_len;
   logic [CNT_W-1:0]      occupancy;
   logic                  strobe;
   logic                  valid;
   logic                  push;
   logic                  pop;

   function automatic logic [1:0] decode_len(input logic [7:0] op);
      if (op[3:1] == 3'b111)
         return 2'd1;
      else if (op[3:2] == 2'b01 || op[3:0] == 4'hD)
         return 2'd3;
      else
         return 2'd2;
   endfunction

   assign ptr1     = head_q + PTR_W'(1);
   assign ptr2     = head_q + PTR_W'(2);
   assign hb0      = fifo_q[head_q];
   assign hb1      = fifo_q[ptr1];
   assign hb2      = fifo_q[ptr2];
   assign head_len = decode_len(hb0);

   // Bytes already queued plus the byte still in flight from memory; a new
   // request is only issued when that total leaves room, so pushes never
   // overflow. rst_n gates the strobe so no request leaves during reset.
   assign occupancy = count_q + CNT_W'(rd_pending_q);
   assign strobe    = rst_n && !bus.redirect && (occupancy < CNT_W'(DEPTH));
   assign valid     = (count_q >= CNT_W'(head_len));
   assign push      = rd_pending_q && !bus.redirect;
   assign pop       = valid && bus.instr_ready && !bus.redirect;

   always_comb begin
      fifo_d       = fifo_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      rd_pending_d = strobe;
      fpc_d        = fpc_q;
      ipc_d        = ipc_q;
      if (bus.redirect) begin
         // Flush wins over push and pop; the in-flight byte is dropped
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         rd_pending_d = 1'b0;
         fpc_d        = bus.redirect_addr;
         ipc_d        = bus.redirect_addr;
      end else begin
         if (strobe)
            fpc_d = fpc_q + ADDR_WIDTH'(1);
         if (push) begin
            fifo_d[tail_q] = bus.mem_data;
            tail_d         = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(head_len);
            ipc_d  = ipc_q + ADDR_WIDTH'(head_len);
         end
         count_d = count_q + CNT_W'(push) - (pop ? CNT_W'(head_len) : CNT_W'(0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            fifo_q[i] <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         rd_pending_q <= 1'b0;
         fpc_q        <= RESET_PC;
         ipc_q        <= RESET_PC;
      end else begin
         fifo_q       <= fifo_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         rd_pending_q <= rd_pending_d;
         fpc_q        <= fpc_d;
         ipc_q        <= ipc_d;
      end
   end

   // Bytes and length read 0 whenever no whole instruction is presented,
   // so stale queue contents never appear on the execute side.
   assign bus.mem_addr    = fpc_q;
   assign bus.mem_strobe  = strobe;
   assign bus.instr_valid = valid;
   assign bus.instr_byte0 = valid ? hb0 : 8'h00;
   assign bus.instr_byte1 = (valid && head_len >= 2'd2) ? hb1 : 8'h00;
   assign bus.instr_byte2 = (valid && head_len == 2'd3) ? hb2 : 8'h00;
   assign bus.instr_len   = valid ? head_len : 2'd0;
   assign bus.instr_pc    = ipc_q;

`ifdef FETCH_PERF_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (bus.redirect && (count_q != '0 || rd_pending_q) && perf_q != 16'hFFFF)
         perf_d = perf_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_q <= '0;
      else
         perf_q <= perf_d;
   end

   assign perf_flush_count = perf_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the processor's inline fetch sequencer.
- Decouples instruction-byte fetch from execute. It prefetches bytes from the synchronous byte memory into a DEPTH-byte queue, decodes instruction length from the opcode, and presents whole 1/2/3-byte instructions to the execute stage over a valid/ready handshake.
- A redirect input flushes the queue on jumps.

Parameters:
ADDR_WIDTH, 8, memory/PC address width; addresses wrap modulo 2^ADDR_WIDTH.
DEPTH, 4, queue capacity in bytes; power of two, minimum 4.
RESET_PC, 0, fetch and instruction PC value after reset.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
mem_addr  output  ADDR_WIDTH  fetch address, registered.
mem_strobe  output  1  read request; memory returns mem_data one edge later.
mem_data  input  8  byte from memory, registered by the memory.
redirect  input  1  jump request, sampled on the clock edge.
redirect_addr  input  ADDR_WIDTH  jump target.
instr_valid  output  1  complete instruction at queue head.
instr_ready  input  1  execute stage accepts.
instr_byte0  output  8  opcode.
instr_byte1  output  8  2nd byte; 0 if instr_len < 2.
instr_byte2  output  8  3rd byte; 0 if instr_len < 3.
instr_len  output  2  1, 2 or 3.
instr_pc  output  ADDR_WIDTH  address of instr_byte0.

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty, rd_pending=0.
  - fpc=RESET_PC, instr_pc=RESET_PC.
  - mem_strobe=0, instr_valid=0, outputs 0.
  - Strobing may begin in the first cycle after rst_n rises.
- Length decode on head byte low nibble L:
  - L[3:1]=111 -> 1.
  - L[3:2]=01 or L=D -> 3.
  - Otherwise -> 2.
- Issue:
  - mem_strobe = !redirect && (count + rd_pending < DEPTH); count is the value before this cycle's pop.
  - mem_addr = fpc.
  - On an edge with strobe: fpc += 1 (wraps), rd_pending <= 1; otherwise rd_pending <= 0.
  - Back-to-back strobes are allowed, giving 1 byte/cycle throughput.
- Capture: on an edge with rd_pending=1 and no redirect, push mem_data at the tail.
- Valid: instr_valid = (count >= len(head)) combinationally. Bytes are read from the queue head through head+2, modulo DEPTH.
- Transfer on an edge with instr_valid && instr_ready:
  - Pop len bytes.
  - instr_pc += len (wraps).
  - Push and pop in the same edge are both honoured.
- Outputs stay stable while instr_valid=1 and instr_ready=0. instr_ready while instr_valid=0 has no effect.
- Redirect on an edge:
  - Queue cleared, rd_pending cleared; an in-flight byte is discarded.
  - fpc <= redirect_addr, instr_pc <= redirect_addr.
  - Takes priority over push and pop. A simultaneous valid&ready transfer counts as consumed but has no queue effect.
- Latency after a redirect at edge E0:
  - Strobe in cycle after E0.
  - 1-byte instruction valid after E2.
  - 3-byte instruction valid after E4 (no stalls).
- Full: no strobe while count + rd_pending = DEPTH. The queue never overflows.
- Empty: instr_valid=0 and execute waits. A partial instruction (count < len) also holds instr_valid low.
- Wrap-around: fetch from address 2^ADDR_WIDTH-1 continues at 0. Instruction bytes straddling the wrap are delivered in order.
- Reset mid-operation discards everything immediately.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds output perf_flush_count [15:0], reset 0.
  - Increments on each redirect edge where count>0 or rd_pending=1, i.e. bytes were discarded.
  - Saturates at FFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Memory 00:FF,01:FE,02:8F after reset, instr_ready=1 -> instr_valid rises after E2 from reset; three 1-byte instructions FF,FE,8F at instr_pc 00,01,02, with byte1=byte2=0.
- Memory 00:06 12 34 (len 3), 03:0C 55 (len 2), instr_ready=1 -> {06,12,34,len3,pc00} then {0C,55,00,len2,pc03}.
- DEPTH=4, stream of 1-byte nops, instr_ready=0 -> mem_strobe drops after 4 strobes, count=4. Outputs stay FF at pc00 until ready, then sustained 1 instr/cycle.
- redirect=1 with redirect_addr=40 while queue holds 3 bytes and a read is pending -> queue empty next cycle, next strobe addr 40, first instr_pc=40, no stale byte delivered. perf_flush_count=1 if FETCH_PERF_EN.
- ADDR_WIDTH=8, redirect to FE, memory FE:06 FF:AA 00:BB -> instr {06,AA,BB}, pc FE, then instr_pc=01.
- rst_n pulsed low mid-fetch of a 3-byte instruction -> all outputs 0 immediately, then restart at RESET_PC.
